// File: rtl/pwm_deadtime_gen_if.sv
// rtl/pwm_deadtime_gen_if.sv - control/status bundle for the complementary PWM generator
interface pwm_deadtime_gen_if #(
  parameter int CNT_W = 10,
  parameter int DT_W  = 4
);
  logic             en;
  logic [CNT_W-1:0] period_i;
  logic [CNT_W-1:0] duty_i;
  logic [DT_W-1:0]  dt_rise_i;
  logic [DT_W-1:0]  dt_fall_i;
  logic             fault_i;
  logic             fault_clr;
  logic             hi_o;
  logic             lo_o;
  logic             period_end;
  logic             faulted;

  // control-loop side
  modport master (
    output en, period_i, duty_i, dt_rise_i, dt_fall_i, fault_i, fault_clr,
    input  hi_o, lo_o, period_end, faulted
  );

  // generator side
  modport slave (
    input  en, period_i, duty_i, dt_rise_i, dt_fall_i, fault_i, fault_clr,
    output hi_o, lo_o, period_end, faulted
  );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// rtl/pwm_deadtime_gen.sv - complementary PWM with shadowed settings, dead time and latched fault
module pwm_deadtime_gen #(
  parameter int CNT_W = 10,
  parameter int DT_W  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  pwm_deadtime_gen_if.slave bus
);

  localparam logic [DT_W-1:0]  RL_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DT_W-1:0]  RL_ONE  = DT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_s;
  logic [CNT_W-1:0] duty_s;
  logic [DT_W-1:0]  dtr_s;
  logic [DT_W-1:0]  dtf_s;
  logic [DT_W-1:0]  run_len_q;
  logic [DT_W-1:0]  run_len;
  logic             raw_q;
  logic             run_q;
  logic             hi_q;
  logic             lo_q;
  logic             pe_q;
  logic             faulted_q;
  logic             run;
  logic             raw;
  logic             at_end;

  assign run    = bus.en & ~faulted_q;
  assign at_end = (cnt == period_s);
  assign raw    = (cnt < duty_s);

  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
  assign bus.period_end = pe_q;
  assign bus.faulted    = faulted_q;

  // run length of the current raw phase; restarts on a raw edge or at start of operation
  always_comb begin
    run_len = '0;
    if (run_q && (raw == raw_q)) begin
      run_len = (run_len_q == RL_MAX) ? RL_MAX : run_len_q + RL_ONE;
    end
  end

  // shadow registers: track inputs while idle, otherwise reload only on the last count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      period_s <= '0;
      duty_s   <= '0;
      dtr_s    <= '0;
      dtf_s    <= '0;
    end else if (!run || at_end) begin
      period_s <= bus.period_i;
      duty_s   <= bus.duty_i;
      dtr_s    <= bus.dt_rise_i;
      dtf_s    <= bus.dt_fall_i;
    end
  end

  // period counter, parked at zero whenever not running
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (!run || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // previous-cycle history used by the run-length counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_len_q <= '0;
      raw_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      run_len_q <= run_len;
      raw_q     <= raw;
      run_q     <= run;
    end
  end

  // gate drives; a fault request blanks them on the same edge that latches the fault
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= 1'b0;
      lo_q <= 1'b0;
      pe_q <= 1'b0;
    end else begin
      pe_q <= run & at_end;
      if (!run || bus.fault_i) begin
        hi_q <= 1'b0;
        lo_q <= 1'b0;
      end else begin
        hi_q <= raw & (run_len >= dtr_s);
        lo_q <= ~raw & (run_len >= dtf_s);
      end
    end
  end

  // latched fault; a live request wins over a clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      faulted_q <= 1'b0;
    end else if (bus.fault_i) begin
      faulted_q <= 1'b1;
    end else if (bus.fault_clr) begin
      faulted_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb/tb_pwm_deadtime_gen.sv - directed self-checking bench for pwm_deadtime_gen
module tb_pwm_deadtime_gen;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  int   cidx;
  logic [63:0] hv;
  logic [63:0] lv;
  logic [63:0] pv;

  pwm_deadtime_gen_if #(.CNT_W(10), .DT_W(4)) ifc ();

  pwm_deadtime_gen #(.CNT_W(10), .DT_W(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cap();
    cidx = 0;
    hv = '0;
    lv = '0;
    pv = '0;
  endtask

  // sample n cycles, 1 time unit after each rising edge, checking the overlap invariant
  task automatic cap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      hv[cidx] = ifc.hi_o;
      lv[cidx] = ifc.lo_o;
      pv[cidx] = ifc.period_end;
      chk("no_overlap", {31'd0, ifc.hi_o & ifc.lo_o}, 32'd0);
      cidx++;
    end
  endtask

  // idle two cycles to load fresh shadows, then enable; next sample is bit 0
  task automatic restart(input int per, input int du, input int dr, input int df);
    ifc.en        = 1'b0;
    ifc.period_i  = 10'(per);
    ifc.duty_i    = 10'(du);
    ifc.dt_rise_i = 4'(dr);
    ifc.dt_fall_i = 4'(df);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    ifc.en = 1'b1;
    clr_cap();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr_cap();
    resetn        = 1'b0;
    ifc.en        = 1'b0;
    ifc.period_i  = '0;
    ifc.duty_i    = '0;
    ifc.dt_rise_i = '0;
    ifc.dt_fall_i = '0;
    ifc.fault_i   = 1'b0;
    ifc.fault_clr = 1'b0;
    #2;
    chk("reset_outputs", {28'd0, ifc.hi_o, ifc.lo_o, ifc.period_end, ifc.faulted}, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // basic pattern: 10-cycle period, hi 3, lo 4, dead 3
    restart(9, 4, 1, 2);
    cap(20);
    chk("t1_hi", hv[31:0], 32'h0000_380E);
    chk("t1_lo", lv[31:0], 32'h000F_03C0);
    chk("t1_pe", pv[31:0], 32'h0008_0200);
    cap(2);
    chk("t1_hi_before_abort", {31'd0, hv[21]}, 32'd1);
    ifc.en = 1'b0;
    cap(1);
    chk("abort_hi", {31'd0, ifc.hi_o}, 32'd0);
    chk("abort_lo", {31'd0, ifc.lo_o}, 32'd0);

    // duty 0 and duty above period
    restart(9, 0, 1, 2);
    cap(20);
    chk("d0_hi", hv[31:0], 32'd0);
    chk("d0_lo", lv[31:0], 32'h000F_FFFC);
    chk("d0_pe", pv[31:0], 32'h0008_0200);
    restart(9, 12, 1, 2);
    cap(20);
    chk("d100_hi", hv[31:0], 32'h000F_FFFE);
    chk("d100_lo", lv[31:0], 32'd0);

    // zero period: period_end every cycle
    restart(0, 1, 0, 0);
    cap(8);
    chk("p0_pe", pv[31:0], 32'h0000_00FF);
    chk("p0_hi", hv[31:0], 32'h0000_00FF);
    chk("p0_lo", lv[31:0], 32'd0);

    // duty 4 -> 7 at cnt=3 takes effect at the next period
    restart(9, 4, 1, 2);
    cap(3);
    ifc.duty_i = 10'd7;
    cap(17);
    chk("shadow_hi", hv[31:0], 32'h0001_F80E);
    chk("shadow_lo", lv[31:0], 32'h0008_03C0);

    // dead time longer than the low phase suppresses lo_o entirely
    restart(9, 4, 1, 7);
    cap(20);
    chk("shortph_hi", hv[31:0], 32'h0000_380E);
    chk("shortph_lo", lv[31:0], 32'd0);

    // fault at cnt=5, clear blocked while fault_i high, restart from cnt=0
    restart(9, 4, 1, 0);
    cap(5);
    chk("f_lo_before", {31'd0, lv[4]}, 32'd1);
    ifc.fault_i = 1'b1;
    cap(1);
    chk("f_outputs_off", {30'd0, ifc.hi_o, ifc.lo_o}, 32'd0);
    chk("f_latched", {31'd0, ifc.faulted}, 32'd1);
    ifc.fault_clr = 1'b1;
    cap(1);
    chk("f_clr_blocked", {31'd0, ifc.faulted}, 32'd1);
    ifc.fault_i   = 1'b0;
    ifc.fault_clr = 1'b0;
    cap(1);
    chk("f_still_latched", {31'd0, ifc.faulted}, 32'd1);
    ifc.fault_clr = 1'b1;
    cap(1);
    chk("f_cleared", {31'd0, ifc.faulted}, 32'd0);
    ifc.fault_clr = 1'b0;
    clr_cap();
    cap(20);
    chk("f_restart_hi", hv[31:0], 32'h0000_380E);
    chk("f_restart_lo", lv[31:0], 32'h000F_C3F0);
    chk("f_restart_pe", pv[31:0], 32'h0008_0200);

    // random sweep with asynchronous reset mid-period
    for (int k = 0; k < 4; k++) begin
      restart(int'($urandom_range(0, 20)), int'($urandom_range(0, 25)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      cap(int'($urandom_range(10, 40)));
      #3;
      resetn = 1'b0;
      #1;
      chk("async_reset", {28'd0, ifc.hi_o, ifc.lo_o, ifc.period_end, ifc.faulted}, 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
